// File: rtl/paddle_key_arbiter_pkg.sv
// Shared types and constants for the PS/2 paddle key arbiter.
// Holds the scan-code constants, the decoder state and key index enums,
// the key event payload, and helpers for key mapping and up/down resolution.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_e;
  typedef enum logic [1:0] {K_LUP, K_LDN, K_RUP, K_RDN} key_idx_e;

  // One decoded key event: valid strobe, make (1) or break (0), which key.
  typedef struct packed {
    logic     valid;
    logic     make;
    key_idx_e key;
  } key_evt_t;

  typedef struct packed {
    logic     hit;
    key_idx_e key;
  } key_map_t;

  // Map a final scan-code byte (plus its extended flag) to a game key.
  function automatic key_map_t map_code(input logic [7:0] code, input logic ext);
    key_map_t m;
    m.hit = 1'b0;
    m.key = K_LUP;
    if (!ext && code == SC_W) begin
      m.hit = 1'b1;
      m.key = K_LUP;
    end else if (!ext && code == SC_S) begin
      m.hit = 1'b1;
      m.key = K_LDN;
    end else if (ext && code == SC_UP) begin
      m.hit = 1'b1;
      m.key = K_RUP;
    end else if (ext && code == SC_DOWN) begin
      m.hit = 1'b1;
      m.key = K_RDN;
    end
    return m;
  endfunction

  // Returns {up, down}; with both held the most recent press wins.
  function automatic logic [1:0] resolve_dir(input logic up, input logic dn,
                                             input logic last_up);
    if (up && dn) begin
      return last_up ? 2'b10 : 2'b01;
    end
    return {up, dn};
  endfunction

endpackage

// File: rtl/paddle_key_arbiter_if.sv
// Bundle of the arbiter's data-path signals.
//   key_byte/key_valid : scan-code byte and its one-cycle strobe
//   sw                 : left-player source (0 keyboard, 1 buttons)
//   btnU/btnD          : raw board buttons, asynchronous
//   up_l/down_l/up_r/down_r : registered paddle commands
// master drives the inputs (receiver/board side), slave is the arbiter.
interface paddle_key_arbiter_if;
  logic [7:0] key_byte;
  logic       key_valid;
  logic       sw;
  logic       btnU;
  logic       btnD;
  logic       up_l;
  logic       down_l;
  logic       up_r;
  logic       down_r;

  modport master (
    output key_byte, key_valid, sw, btnU, btnD,
    input  up_l, down_l, up_r, down_r
  );

  modport slave (
    input  key_byte, key_valid, sw, btnU, btnD,
    output up_l, down_l, up_r, down_r
  );
endinterface

// File: rtl/paddle_key_arbiter_decoder.sv
// PS/2 scan-code prefix decoder (E0 extended, F0 break, E1 pause abort).
// Emits a combinational one-cycle key event on the final byte of a mapped code.
//   clk, rst (async active-low)
//   key_byte/key_valid : received byte and strobe
//   flush              : force the FSM back to IDLE (watchdog expiry)
//   evt_c              : key event for this cycle
module ps2_scan_decoder
  import keyboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_byte,
  input  logic       key_valid,
  input  logic       flush,
  output key_evt_t   evt_c
);

  dec_state_e state_q, state_d;
  logic       emit;
  logic       ext;
  logic       make;
  key_map_t   map;

  // Next state and event decode; only a strobed byte advances the FSM.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ext     = 1'b0;
    make    = 1'b0;
    if (key_valid) begin
      if (key_byte == SC_PAUSE) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (key_byte == SC_BRK)      state_d = BRK;
            else if (key_byte == SC_EXT) state_d = EXT;
            else begin
              emit = 1'b1;
              make = 1'b1;
            end
          end
          EXT: begin
            if (key_byte == SC_BRK)      state_d = EXT_BRK;
            else if (key_byte == SC_EXT) state_d = EXT;
            else begin
              emit    = 1'b1;
              ext     = 1'b1;
              make    = 1'b1;
              state_d = IDLE;
            end
          end
          BRK: begin
            emit    = 1'b1;
            state_d = IDLE;
          end
          EXT_BRK: begin
            emit    = 1'b1;
            ext     = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (flush) begin
      state_d = IDLE;
    end
    map         = map_code(key_byte, ext);
    evt_c       = '0;
    evt_c.valid = emit & map.hit;
    evt_c.make  = make;
    evt_c.key   = map.key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

endmodule

// File: rtl/paddle_key_arbiter.sv
// Paddle key arbiter: tracks held game keys from PS/2 scan codes, resolves
// up/down conflicts per player, muxes board buttons onto the left player,
// and registers the four paddle commands.
//   clk, rst (async active-low)
//   bus : paddle_key_arbiter_if.slave (key bytes, switch, buttons, commands)
// Optional: define KEY_WATCHDOG_EN to force-release held keys after
// WDOG_CYCLES cycles without any received byte.
module paddle_key_arbiter
  import keyboard_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 65_000_000
) (
  input logic                 clk,
  input logic                 rst,
  paddle_key_arbiter_if.slave bus
);

  if (WDOG_CYCLES < 2) begin : g_wdog_range_chk
    $error("WDOG_CYCLES must be at least 2");
  end

  key_evt_t              evt_c;
  logic                  wdog_expire_c;
  logic [NUM_KEYS-1:0]   held_q, held_d;
  logic                  last_l_q, last_l_d;
  logic                  last_r_q, last_r_d;
  logic [1:0]            btn_meta_q, btn_meta_d;
  logic [1:0]            btn_sync_q, btn_sync_d;
  logic                  up_l_q, up_l_d, down_l_q, down_l_d;
  logic                  up_r_q, up_r_d, down_r_q, down_r_d;
  logic [1:0]            kb_l, kb_r, btn_l, sel_l;

  ps2_scan_decoder u_decoder (
    .clk       (clk),
    .rst       (rst),
    .key_byte  (bus.key_byte),
    .key_valid (bus.key_valid),
    .flush     (wdog_expire_c),
    .evt_c     (evt_c)
  );

`ifdef KEY_WATCHDOG_EN
  localparam int unsigned WDOG_MAX = WDOG_CYCLES - 1;
  logic [31:0] wdog_q, wdog_d;

  // Idle counter: cleared by any byte, saturates at the expiry value.
  always_comb begin
    wdog_d        = wdog_q;
    wdog_expire_c = 1'b0;
    if (bus.key_valid)                begin wdog_d = '0; end
    else if (wdog_q == 32'(WDOG_MAX)) begin wdog_expire_c = 1'b1; end
    else                              begin wdog_d = wdog_q + 32'd1; end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`else
  assign wdog_expire_c = 1'b0;
`endif

  // Held bitmap, last-pressed flags, resolution and source select.
  always_comb begin
    held_d     = held_q;
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
    btn_meta_d = {bus.btnU, bus.btnD};
    btn_sync_d = btn_meta_q;
    if (evt_c.valid) begin
      held_d[evt_c.key] = evt_c.make;
      if (evt_c.make) begin
        case (evt_c.key)
          K_LUP:   last_l_d = 1'b1;
          K_LDN:   last_l_d = 1'b0;
          K_RUP:   last_r_d = 1'b1;
          default: last_r_d = 1'b0;
        endcase
      end
    end
    if (wdog_expire_c) held_d = '0;
    kb_l  = resolve_dir(held_d[K_LUP], held_d[K_LDN], last_l_d);
    kb_r  = resolve_dir(held_d[K_RUP], held_d[K_RDN], last_r_d);
    btn_l = {btn_sync_q[1] & ~btn_sync_q[0], btn_sync_q[0] & ~btn_sync_q[1]};
    sel_l = bus.sw ? btn_l : kb_l;
    up_l_d   = sel_l[1];
    down_l_d = sel_l[0];
    up_r_d   = kb_r[1];
    down_r_d = kb_r[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q     <= '0;
      last_l_q   <= 1'b0;
      last_r_q   <= 1'b0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      up_l_q     <= 1'b0;
      down_l_q   <= 1'b0;
      up_r_q     <= 1'b0;
      down_r_q   <= 1'b0;
    end else begin
      held_q     <= held_d;
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      up_l_q     <= up_l_d;
      down_l_q   <= down_l_d;
      up_r_q     <= up_r_d;
      down_r_q   <= down_r_d;
    end
  end

  assign bus.up_l   = up_l_q;
  assign bus.down_l = down_l_q;
  assign bus.up_r   = up_r_q;
  assign bus.down_r = down_r_q;

endmodule

// File: tb/tb_paddle_key_arbiter.sv
// Directed bench for paddle_key_arbiter. Outputs are compared as the nibble
// {up_l, down_l, up_r, down_r}, sampled on the falling clock edge.
module tb_paddle_key_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  paddle_key_arbiter_if bus ();

  paddle_key_arbiter #(.WDOG_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus.up_l, bus.down_l, bus.up_r, bus.down_r};
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = outs();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One strobed byte; returns on the falling edge after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.key_byte  = b;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.key_byte  = 8'h00;
    bus.key_valid = 1'b0;
    bus.sw        = 1'b0;
    bus.btnU      = 1'b0;
    bus.btnD      = 1'b0;
    #1 rst = 1'b0;
    #2 check("reset_async", 4'b0000);
    idle(2);
    check("reset_held", 4'b0000);
    rst = 1'b1;

    // Left keyboard make/break
    send(8'h1D);             check("w_make", 4'b1000);
    send(8'hF0); send(8'h1D); check("w_break", 4'b0000);

    // Right player conflict: newest press wins, break reverts to the other
    send(8'hE0); send(8'h75); check("rup_make", 4'b0010);
    send(8'hE0);              check("ext_prefix_only", 4'b0010);
    send(8'h72);              check("rdn_over_rup", 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h72); check("rdn_break", 4'b0010);
    send(8'hE0); send(8'hF0); send(8'h75); check("rup_break", 4'b0000);

    // Left conflict and typematic refresh of the last flag
    send(8'h1D); send(8'h1B); check("ldn_over_lup", 4'b0100);
    send(8'h1D);              check("lup_repeat", 4'b1000);
    send(8'hF0); send(8'h1D); check("lup_break", 4'b0100);
    send(8'hF0); send(8'h1B); check("ldn_break", 4'b0000);

    // Unmapped / wrong-prefix codes
    send(8'h75);              check("plain_75", 4'b0000);
    send(8'hE0); send(8'h1D); check("ext_1d", 4'b0000);
    send(8'h1C);              check("unmapped", 4'b0000);

    // Pause prefix aborts the extended sequence
    send(8'hE0); send(8'hE1); send(8'h1D); check("pause_abort", 4'b1000);
    send(8'hF0); send(8'h1D); check("pause_w_break", 4'b0000);

    // Button path: 3-cycle latency, keyboard still tracked underneath
    @(negedge clk);
    bus.sw        = 1'b1;
    bus.btnU      = 1'b1;
    bus.key_byte  = 8'h1B;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("btn_lat1", 4'b0000);
    idle(1); check("btn_lat2", 4'b0000);
    idle(1); check("btn_lat3", 4'b1000);
    bus.btnD = 1'b1;
    idle(2); check("btn_both_lat2", 4'b1000);
    idle(1); check("btn_both", 4'b0000);
    bus.sw = 1'b0;
    idle(1); check("sw_back_kbd", 4'b0100);
    bus.btnU = 1'b0;
    bus.btnD = 1'b0;
    send(8'hF0); send(8'h1B); check("s_break", 4'b0000);

    // Reset mid-sequence discards the pending E0 and clears outputs
    send(8'hE0); send(8'h75); check("rup_pre_reset", 4'b0010);
    send(8'hE0);
    rst = 1'b0;
    #2 check("reset_mid_async", 4'b0000);
    idle(1);
    rst = 1'b1;
    send(8'h75); check("post_reset_75", 4'b0000);

`ifdef KEY_WATCHDOG_EN
    send(8'h1D);
    idle(90); check("wdog_still_held", 4'b1000);
    idle(15); check("wdog_expired", 4'b0000);
    send(8'h1D);
    idle(48);
    send(8'h1D);
    idle(80); check("wdog_refreshed", 4'b1000);
    idle(30); check("wdog_refresh_expired", 4'b0000);
    send(8'hE0);
    idle(110);
    send(8'h75); check("wdog_fsm_idle", 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
